// File: rtl/axi_mem_arbiter.sv
// axi_mem_arbiter: shares one AXI4-Lite memory slave between a read-only fetch port (S0)
// and a read/write data port (S1), one transaction in flight, alternating on ties.
module axi_mem_arbiter #(
    parameter int AXI_AWIDTH = 4,
    parameter int AXI_DWIDTH = 32
) (
    input  logic                    AXI_ACLK,
    input  logic                    AXI_ARESET,
    input  logic [AXI_AWIDTH-1:0]   S0_ARADDR,
    input  logic                    S0_ARVALID,
    output logic                    S0_ARREADY,
    output logic [AXI_DWIDTH-1:0]   S0_RDATA,
    output logic [1:0]              S0_RRESP,
    output logic                    S0_RVALID,
    input  logic                    S0_RREADY,
    input  logic [AXI_AWIDTH-1:0]   S1_AWADDR,
    input  logic                    S1_AWVALID,
    output logic                    S1_AWREADY,
    input  logic [AXI_DWIDTH-1:0]   S1_WDATA,
    input  logic [AXI_DWIDTH/8-1:0] S1_WSTRB,
    input  logic                    S1_WVALID,
    output logic                    S1_WREADY,
    output logic [1:0]              S1_BRESP,
    output logic                    S1_BVALID,
    input  logic                    S1_BREADY,
    input  logic [AXI_AWIDTH-1:0]   S1_ARADDR,
    input  logic                    S1_ARVALID,
    output logic                    S1_ARREADY,
    output logic [AXI_DWIDTH-1:0]   S1_RDATA,
    output logic [1:0]              S1_RRESP,
    output logic                    S1_RVALID,
    input  logic                    S1_RREADY,
    output logic [AXI_AWIDTH-1:0]   M_AWADDR,
    output logic                    M_AWVALID,
    input  logic                    M_AWREADY,
    output logic [AXI_DWIDTH-1:0]   M_WDATA,
    output logic [AXI_DWIDTH/8-1:0] M_WSTRB,
    output logic                    M_WVALID,
    input  logic                    M_WREADY,
    input  logic [1:0]              M_BRESP,
    input  logic                    M_BVALID,
    output logic                    M_BREADY,
    output logic [AXI_AWIDTH-1:0]   M_ARADDR,
    output logic                    M_ARVALID,
    input  logic                    M_ARREADY,
    input  logic [AXI_DWIDTH-1:0]   M_RDATA,
    input  logic [1:0]              M_RRESP,
    input  logic                    M_RVALID,
    output logic                    M_RREADY
);
    typedef enum logic [1:0] {IDLE, GNT_F, GNT_DR, GNT_DW} state_t;
    state_t state;
    logic last_grant, ar_done, aw_done, w_done;
    logic gf, gdr, gdw, rq_f, rq_w, rq_d, pick_d, done;

    assign gf  = state == GNT_F;
    assign gdr = state == GNT_DR;
    assign gdw = state == GNT_DW;
    assign rq_f = S0_ARVALID;
    assign rq_w = S1_AWVALID & S1_WVALID;
    assign rq_d = rq_w | S1_ARVALID;
    // data wins when alone, or on a tie when fetch had the last grant
    assign pick_d = rq_d & (~rq_f | ~last_grant);
    assign done = ((gf | gdr) & M_RVALID & M_RREADY) | (gdw & M_BVALID & M_BREADY);

    always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
        if (AXI_ARESET) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            ar_done    <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else if (state == IDLE) begin
            if (rq_f | rq_d) begin
                state      <= pick_d ? (rq_w ? GNT_DW : GNT_DR) : GNT_F;
                last_grant <= pick_d;
            end
        end else if (done) begin
            state   <= IDLE;
            ar_done <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            ar_done <= ar_done | (M_ARVALID & M_ARREADY);
            aw_done <= aw_done | (M_AWVALID & M_AWREADY);
            w_done  <= w_done | (M_WVALID & M_WREADY);
        end
    end

    assign M_ARADDR   = gf ? S0_ARADDR : gdr ? S1_ARADDR : '0;
    assign M_ARVALID  = ~ar_done & (gf ? S0_ARVALID : gdr & S1_ARVALID);
    assign S0_ARREADY = gf & M_ARREADY & ~ar_done;
    assign S1_ARREADY = gdr & M_ARREADY & ~ar_done;
    assign M_RREADY   = gf ? S0_RREADY : gdr & S1_RREADY;
    assign S0_RVALID  = gf & M_RVALID;
    assign S1_RVALID  = gdr & M_RVALID;
    assign S0_RDATA   = M_RDATA;
    assign S1_RDATA   = M_RDATA;
    assign S0_RRESP   = M_RRESP;
    assign S1_RRESP   = M_RRESP;

    assign M_AWADDR   = gdw ? S1_AWADDR : '0;
    assign M_AWVALID  = gdw & S1_AWVALID & ~aw_done;
    assign S1_AWREADY = gdw & M_AWREADY & ~aw_done;
    assign M_WDATA    = gdw ? S1_WDATA : '0;
    assign M_WSTRB    = gdw ? S1_WSTRB : '0;
    assign M_WVALID   = gdw & S1_WVALID & ~w_done;
    assign S1_WREADY  = gdw & M_WREADY & ~w_done;
    assign M_BREADY   = gdw & S1_BREADY;
    assign S1_BVALID  = gdw & M_BVALID;
    assign S1_BRESP   = M_BRESP;
endmodule

// File: doc/axi_mem_arbiter.md
# axi_mem_arbiter

Two-master, one-slave AXI4-Lite arbiter that shares the single-ported RV32I core memory between the instruction-fetch port (read-only) and the load/store port (read/write). It sits between the core's fetch and data AXI masters and the memory slave. It allows exactly one transaction in flight, fairly alternates fetch and data when both request, and passes handshakes and responses through unmodified.

## Interface
- AXI_AWIDTH, 4, address width on all ports
- AXI_DWIDTH, 32, data width on all ports; strobe width AXI_DWIDTH/8

- AXI_ACLK  in  1  single clock, rising edge
- AXI_ARESET  in  1  asynchronous, active-high reset
- S0_ARADDR/ARVALID/ARREADY, S0_RDATA/RRESP/RVALID/RREADY  fetch read channels (S0_ARREADY, S0_R* outputs)
- S1_AWADDR/AWVALID/AWREADY, S1_WDATA/WSTRB/WVALID/WREADY, S1_BRESP/BVALID/BREADY  data write channels (S1_AWREADY, S1_WREADY, S1_B* outputs)
- S1_ARADDR/ARVALID/ARREADY, S1_RDATA/RRESP/RVALID/RREADY  data read channels
- M_*  full AXI4-Lite master to memory (AW, W, B, AR, R); same widths as above

## Operation
- Requests, sampled in IDLE: rq_f = S0_ARVALID; rq_w = S1_AWVALID & S1_WVALID; rq_r = S1_ARVALID. S1 must present AW and W together; AW without W is not a request.
- Data-port request rq_d = rq_w | rq_r. Within the data port, write beats read.
- Fairness: 1-bit last_grant (0 = fetch, 1 = data). If rq_f and rq_d are both set, the side not in last_grant wins. If only one is set, that side wins. last_grant updates on entry to a grant state.
- States: IDLE, GNT_F (S0 read), GNT_DR (S1 read), GNT_DW (S1 write).
- In a read grant: M_ARADDR = granted ARADDR, M_ARVALID = granted ARVALID & ~ar_done, granted ARREADY = M_ARREADY & ~ar_done, M_RREADY = granted RREADY, granted RVALID = M_RVALID. RDATA/RRESP are forwarded.
- In the write grant: AW and W are handled the same way with aw_done and w_done. M_BREADY = S1_BREADY and S1_BVALID = M_BVALID. BRESP is forwarded.
- ar_done/aw_done/w_done are set on the channel handshake and cleared on return to IDLE. A handshake on the same cycle as completion needs no flag.
- Completion: R handshake (M_RVALID & M_RREADY) in read grants, B handshake in GNT_DW, then IDLE on the next edge.
- Non-granted masters: all ready/valid outputs are 0.
- IDLE: all M_* valid and ready outputs are 0, and M_* address/data/strobe are 0.
- S0_RDATA/S1_RDATA = M_RDATA and RRESP/BRESP are broadcast unconditionally. Only the valids are gated.
- Masters must hold valid and payload stable until ready (AXI rule). Withdrawal while pending is illegal and unchecked.

## Timing
- Reset (async assert, sync release): state IDLE, done flags 0, last_grant = 1, so fetch wins the first tie. All valid/ready outputs are 0 immediately on assertion.
- Reset mid-transaction: the grant is dropped at once with no response to the requester. Memory-side recovery is the system reset's responsibility.
- Grant latency: a request visible at edge n gives the grant state and M_*VALID high after edge n+1. Outputs are combinational from state and flags.
- Minimum of one IDLE cycle between consecutive transactions.
- Against the core memory (ARREADY and RVALID in the same cycle, one cycle after ARVALID & RREADY):
  - a read takes 3 cycles from request to IDLE;
  - a write takes 3 cycles from request to IDLE.
- Stalled responses (RREADY/BREADY low) hold the grant indefinitely. There is no timeout.

## Test plan
- Single fetch: S0 ARADDR=0x4 with memory word 0x00000013 -> M_ARVALID after 1 cycle; S0_RVALID=1 with RDATA=0x00000013 and RRESP=0 on one cycle; S1 sees no valid.
- Data write: S1 AWADDR=0x8, WDATA=0xCAFEBABE, WSTRB=0xF -> one S1_BVALID with BRESP=0; a later S0 read of 0x8 returns 0xCAFEBABE.
- Tie, fetch and data read held continuously for 6 grants -> order after reset is F, D, F, D, F, D.
- S1 write and read pending together, no fetch -> write granted first, then read, which returns the newly written data.
- Response backpressure: S0_RREADY held low for 5 cycles during GNT_F -> state stays GNT_F, no M_ARVALID reissue after ar_done, and S1 requests wait.
- AXI_ARESET asserted during GNT_DW -> all S*/M_* valid/ready outputs go 0 in the same cycle; after release, the first tie goes to fetch.
